vga_pmod_rx: RTL and testbench

VGA_PMOD_RX -- requirements
Module: vga_pmod_rx

---
 rtl/vga_pmod_rx.sv | 180 ++++++++++++++++++
 tb/tb_vga_pmod_rx.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pmod_rx.sv
// Tiny VGA Pmod receiver: recovers pixel position from the sync pins.
// It locks onto the stream and produces a signature of each clean frame.
module vga_pmod_rx #(
    parameter int H_ACTIVE        = 640,
    parameter int H_TOTAL         = 800,
    parameter int H_SYNC_START    = 656,
    parameter int V_ACTIVE        = 480,
    parameter int V_TOTAL         = 525,
    parameter int V_SYNC_START    = 490,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  pmod,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [5:0]  pix_rgb,
    output logic        locked,
    output logic        line_err,
    output logic        frame_err,
    output logic        frame_done,
    output logic [15:0] frame_sig,
    output logic [8:0]  frame_count
);

    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_SS   = 10'(H_SYNC_START);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_SS   = 10'(V_SYNC_START);

    typedef enum logic [1:0] {
        UNLOCKED,
        HSYNCED,
        ACQUIRE,
        LOCKED
    } state_t;

    state_t      state;
    state_t      state_n;

    logic [7:0]  s1;
    logic        s1_vld;
    logic        hs_prev;
    logic        vs_prev;
    logic [9:0]  h_q;
    logic [9:0]  v_q;
    logic [15:0] acc;
    logic        err_flag;

    logic        hs_now;
    logic        vs_now;
    logic        hs_edge;
    logic        vs_edge;
    logic [9:0]  h_inc;
    logic [9:0]  h_cur;
    logic        h_wrap;
    logic [9:0]  v_inc;
    logic [9:0]  v_cur;
    logic        checking;
    logic        l_err;
    logic        f_err;
    logic        active;
    logic        show;
    logic        bad;
    logic        sig_upd;
    logic [5:0]  rgb;

    // The reset value of S1 must not look like an asserted sync pulse.
    assign hs_now  = s1_vld & (s1[7] ^ SYNC_ACTIVE_LOW);
    assign vs_now  = s1_vld & (s1[3] ^ SYNC_ACTIVE_LOW);
    assign hs_edge = hs_now & ~hs_prev;
    assign vs_edge = vs_now & ~vs_prev;

    assign h_inc  = (h_q == H_LAST) ? 10'd0 : h_q + 10'd1;
    assign h_cur  = hs_edge ? H_SS : h_inc;
    assign h_wrap = ~hs_edge & (h_q == H_LAST);

    always_comb begin
        v_inc = v_q;
        if (h_wrap) begin
            v_inc = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
        end
    end

    assign v_cur = vs_edge ? V_SS : v_inc;

    assign checking = (state == ACQUIRE) || (state == LOCKED);
    assign l_err    = checking & hs_edge & (h_inc != H_SS);
    assign f_err    = checking & vs_edge &
                      ((v_inc != V_SS) | (h_cur != 10'd0));

    assign active  = (h_cur < H_ACT) && (v_cur < V_ACT);
    assign show    = (state == LOCKED) & active;
    assign bad     = err_flag | l_err | f_err;
    assign sig_upd = vs_edge & (state == LOCKED) & ~bad;
    assign rgb     = {s1[0], s1[4], s1[1], s1[5], s1[2], s1[6]};

    always_comb begin
        state_n = state;
        unique case (state)
            UNLOCKED: if (hs_edge) state_n = HSYNCED;
            HSYNCED:  if (vs_edge) state_n = ACQUIRE;
            ACQUIRE:  if (vs_edge && !bad) state_n = LOCKED;
            LOCKED:   if (line_err || frame_err) state_n = ACQUIRE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= UNLOCKED;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1      <= 8'd0;
            s1_vld  <= 1'b0;
            hs_prev <= 1'b0;
            vs_prev <= 1'b0;
            h_q     <= 10'd0;
            v_q     <= 10'd0;
        end else begin
            s1      <= pmod;
            s1_vld  <= 1'b1;
            hs_prev <= hs_now;
            vs_prev <= vs_now;
            h_q     <= h_cur;
            v_q     <= v_cur;
        end
    end

    // Errors seen in the vs-edge cycle count against the frame just ending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_flag <= 1'b0;
            acc      <= 16'd0;
        end else begin
            err_flag <= vs_edge ? 1'b0 : (err_flag | l_err | f_err);
            if (vs_edge) begin
                acc <= 16'd0;
            end else if (checking && active) begin
                acc <= {acc[14:0], acc[15]} ^ {10'd0, rgb};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_valid   <= 1'b0;
            pix_x       <= 10'd0;
            pix_y       <= 10'd0;
            pix_rgb     <= 6'd0;
            line_err    <= 1'b0;
            frame_err   <= 1'b0;
            frame_done  <= 1'b0;
            frame_sig   <= 16'd0;
            frame_count <= 9'd0;
        end else begin
            pix_valid  <= show;
            pix_x      <= h_cur;
            pix_y      <= v_cur;
            pix_rgb    <= show ? rgb : 6'd0;
            line_err   <= l_err;
            frame_err  <= f_err;
            frame_done <= sig_upd;
            if (sig_upd) begin
                frame_sig   <= acc;
                frame_count <= frame_count + 9'd1;
            end
        end
    end

    assign locked = (state == LOCKED);

endmodule

// File: tb/tb_vga_pmod_rx.sv
// Directed bench for vga_pmod_rx using a reduced 24x12 raster.
// Signature boundaries keep the 640x480 values (128 pixels, 127 = 15 mod 16).
module tb_vga_pmod_rx;

    localparam int HA  = 16;
    localparam int HT  = 24;
    localparam int HSS = 18;
    localparam int VA  = 8;
    localparam int VT  = 12;
    localparam int VSS = 9;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  pmod = 8'h88;
    logic        pix_valid;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [5:0]  pix_rgb;
    logic        locked;
    logic        line_err;
    logic        frame_err;
    logic        frame_done;
    logic [15:0] frame_sig;
    logic [8:0]  frame_count;

    vga_pmod_rx #(
        .H_ACTIVE(HA), .H_TOTAL(HT), .H_SYNC_START(HSS),
        .V_ACTIVE(VA), .V_TOTAL(VT), .V_SYNC_START(VSS),
        .SYNC_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pmod(pmod),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .pix_rgb(pix_rgb), .locked(locked),
        .line_err(line_err), .frame_err(frame_err),
        .frame_done(frame_done), .frame_sig(frame_sig),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int hx = 0;
    int vy = 0;
    int hot_x = -1;
    int hot_y = -1;
    logic [7:0] hot_col = 8'h00;
    int skip_x = -1;
    int skip_y = -1;
    bit force_both = 1'b0;

    int n_done = 0;
    int n_lerr = 0;
    int n_ferr = 0;
    logic [15:0] last_sig = 16'h0;
    logic [8:0]  last_cnt = 9'h0;
    logic lock_at_lerr = 1'b0;
    logic lock_after_lerr = 1'b1;
    logic lerr_prev = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_done) begin
                n_done   <= n_done + 1;
                last_sig <= frame_sig;
                last_cnt <= frame_count;
            end
            if (line_err) begin
                n_lerr       <= n_lerr + 1;
                lock_at_lerr <= locked;
            end
            if (lerr_prev) lock_after_lerr <= locked;
            lerr_prev <= line_err;
            if (frame_err) n_ferr <= n_ferr + 1;
        end
    end

    function automatic logic [7:0] mk(input int x, input int y);
        logic [7:0] p;
        p = (x == hot_x && y == hot_y) ? hot_col : 8'h00;
        p[7] = !(x >= HSS && x < HSS + 3);
        p[3] = !(y >= VSS && y < VSS + 2);
        return p;
    endfunction

    task automatic step();
        @(negedge clk);
        pmod = mk(hx, vy);
        if (force_both) begin
            pmod[7] = 1'b0;
            pmod[3] = 1'b0;
            force_both = 1'b0;
        end
        hx++;
        if (hx == HT) begin
            hx = 0;
            vy = (vy == VT - 1) ? 0 : vy + 1;
        end
        if (hx == skip_x && vy == skip_y) begin
            hx++;
            skip_x = -1;
        end
    endtask

    task automatic run_until(input int x, input int y);
        for (int i = 0; i < HT * VT * 2; i++) begin
            if (hx == x && vy == y) break;
            step();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pmod  = 8'h88;
        repeat (3) @(negedge clk);
        checks++;
        if ({locked, pix_valid, line_err, frame_err, frame_done} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 00000",
                     {locked, pix_valid, line_err, frame_err, frame_done});
        end
        checks++;
        if ({pix_x, pix_y, pix_rgb} !== 26'h0) begin
            errors++;
            $display("FAIL reset_pix got %0h/%0h/%0h want 0", pix_x, pix_y, pix_rgb);
        end
        checks++;
        if ({frame_sig, frame_count} !== 25'h0) begin
            errors++;
            $display("FAIL reset_sig got %0h/%0d want 0", frame_sig, frame_count);
        end
        rst_n = 1'b1;
        hx = 0;
        vy = 0;
    endtask

    task automatic test_lock();
        run_until(0, VSS);
        repeat (3) step();
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL lock_vs1 got %b want 0", locked);
        end
        run_until(0, VSS);
        step();
        step();
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL lock_vs2_early got %b want 0", locked);
        end
        step();
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL lock_vs2 got %b want 1", locked);
        end
        checks++;
        if (n_lerr != 0 || n_ferr != 0) begin
            errors++;
            $display("FAIL lock_errs got %0d/%0d want 0/0", n_lerr, n_ferr);
        end
        run_until(0, VSS);
        repeat (4) step();
        checks++;
        if (n_done != 1 || last_sig !== 16'h0000 || last_cnt !== 9'd1) begin
            errors++;
            $display("FAIL first_done got %0d/%0h/%0d want 1/0/1",
                     n_done, last_sig, last_cnt);
        end
    endtask

    task automatic test_pixel();
        hot_x = 5;
        hot_y = 7;
        hot_col = 8'h77;
        run_until(5, 7);
        repeat (3) step();
        checks++;
        if ({pix_valid, pix_x, pix_y, pix_rgb} !== {1'b1, 10'd5, 10'd7, 6'h3F}) begin
            errors++;
            $display("FAIL pix_hot got %b/%0d/%0d/%0h want 1/5/7/3f",
                     pix_valid, pix_x, pix_y, pix_rgb);
        end
        step();
        checks++;
        if ({pix_valid, pix_x, pix_rgb} !== {1'b1, 10'd6, 6'h00}) begin
            errors++;
            $display("FAIL pix_black got %b/%0d/%0h want 1/6/0",
                     pix_valid, pix_x, pix_rgb);
        end
        hot_x = -1;
        run_until(15, 7);
        repeat (3) step();
        checks++;
        if ({pix_valid, pix_x} !== {1'b1, 10'd15}) begin
            errors++;
            $display("FAIL pix_last got %b/%0d want 1/15", pix_valid, pix_x);
        end
        step();
        checks++;
        if ({pix_valid, pix_x, pix_rgb} !== {1'b0, 10'd16, 6'h00}) begin
            errors++;
            $display("FAIL pix_blank got %b/%0d/%0h want 0/16/0",
                     pix_valid, pix_x, pix_rgb);
        end
    endtask

    task automatic test_signature();
        int base;
        logic [8:0] cnt0;
        run_until(0, VSS);
        repeat (4) step();
        base = n_done;
        cnt0 = last_cnt;
        hot_x = 0;
        hot_y = 0;
        hot_col = 8'h40;
        run_until(0, VSS);
        repeat (4) step();
        checks++;
        if (n_done != base + 1 || last_sig !== 16'h8000) begin
            errors++;
            $display("FAIL sig_first got %0d/%0h want %0d/8000",
                     n_done, last_sig, base + 1);
        end
        checks++;
        if (last_cnt !== cnt0 + 9'd1) begin
            errors++;
            $display("FAIL sig_count got %0d want %0d", last_cnt, cnt0 + 9'd1);
        end
        hot_x = 15;
        hot_y = 7;
        run_until(0, VSS);
        repeat (4) step();
        checks++;
        if (n_done != base + 2 || last_sig !== 16'h0001) begin
            errors++;
            $display("FAIL sig_last got %0d/%0h want %0d/0001",
                     n_done, last_sig, base + 2);
        end
        hot_x = -1;
    endtask

    task automatic test_line_err();
        int bd;
        int bl;
        int bf;
        bd = n_done;
        bl = n_lerr;
        bf = n_ferr;
        skip_x = 2;
        skip_y = 3;
        run_until(0, 5);
        checks++;
        if (n_lerr != bl + 1 || lock_at_lerr !== 1'b1 || lock_after_lerr !== 1'b0) begin
            errors++;
            $display("FAIL short_line got %0d/%b/%b want %0d/1/0",
                     n_lerr, lock_at_lerr, lock_after_lerr, bl + 1);
        end
        checks++;
        if (locked !== 1'b0 || n_ferr != bf) begin
            errors++;
            $display("FAIL short_line_state got %b/%0d want 0/%0d", locked, n_ferr, bf);
        end
        run_until(0, VSS);
        repeat (4) step();
        checks++;
        if (locked !== 1'b0 || n_done != bd) begin
            errors++;
            $display("FAIL err_frame got %b/%0d want 0/%0d", locked, n_done, bd);
        end
        run_until(0, VSS);
        repeat (3) step();
        checks++;
        if (locked !== 1'b1 || n_done != bd || n_lerr != bl + 1) begin
            errors++;
            $display("FAIL relock got %b/%0d/%0d want 1/%0d/%0d",
                     locked, n_done, n_lerr, bd, bl + 1);
        end
    endtask

    task automatic test_midframe_reset();
        int bd;
        run_until(0, 5);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({locked, pix_valid, frame_count, frame_sig} !== 27'h0) begin
            errors++;
            $display("FAIL mid_reset got %b/%b/%0d/%0h want 0/0/0/0",
                     locked, pix_valid, frame_count, frame_sig);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bd = n_done;
        run_until(0, VSS);
        repeat (3) step();
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL rl_vs1 got %b want 0", locked);
        end
        run_until(0, VSS);
        repeat (3) step();
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL rl_vs2 got %b want 1", locked);
        end
        run_until(0, VSS);
        repeat (4) step();
        checks++;
        if (n_done != bd + 1 || last_cnt !== 9'd1 || last_sig !== 16'h0) begin
            errors++;
            $display("FAIL rl_done got %0d/%0d/%0h want %0d/1/0",
                     n_done, last_cnt, last_sig, bd + 1);
        end
    endtask

    task automatic test_both_edges();
        run_until(5, 4);
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL both_pre got %b want 1", locked);
        end
        force_both = 1'b1;
        repeat (3) step();
        checks++;
        if ({line_err, frame_err} !== 2'b11) begin
            errors++;
            $display("FAIL both_errs got %b want 11", {line_err, frame_err});
        end
        checks++;
        if (pix_x !== 10'(HSS) || pix_y !== 10'(VSS)) begin
            errors++;
            $display("FAIL both_cnt got %0d/%0d want %0d/%0d", pix_x, pix_y, HSS, VSS);
        end
        step();
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL both_drop got %b want 0", locked);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_pixel();
        test_signature();
        test_line_err();
        test_midframe_reset();
        test_both_edges();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
